// File: rtl/gf571_pkg.sv
// rtl/gf571_pkg.sv - shared constants and types for the GF(2^571) Karatsuba multiply scheduler
package gf571_pkg;

  localparam int GF_M        = 571;
  localparam int W_LO        = 285;
  localparam int W_HI        = 286;
  localparam int PROD_W      = 1141;
  localparam int CORE_PROD_W = 571;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMBINE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    KS_Z0 = 2'd0,
    KS_Z1 = 2'd1,
    KS_Z2 = 2'd2
  } ks_step_t;

  // Tag travelling alongside each core operation so its result can be routed.
  typedef struct packed {
    logic     valid;
    ks_step_t k;
  } tag_t;

endpackage

// File: rtl/gf571_kmul_sched_if.sv
// rtl/gf571_kmul_sched_if.sv - operand and product handshake bundle
interface gf571_kmul_sched_if;

  logic                           in_valid;
  logic                           in_ready;
  logic [gf571_pkg::GF_M-1:0]     a;
  logic [gf571_pkg::GF_M-1:0]     b;
  logic                           out_valid;
  logic                           out_ready;
  logic [gf571_pkg::PROD_W-1:0]   d;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d
  );

endinterface

// File: rtl/gf571_kmul_tagpipe.sv
// rtl/gf571_kmul_tagpipe.sv - issue-tag delay line matching the multiplier core latency
module gf571_kmul_tagpipe import gf571_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign tag_out = tag_in;
    end else begin : g_pipe
      tag_t stage [DEPTH];

      // Shift tags one stage per cycle; reset flushes every in-flight tag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= tag_in;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign tag_out = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/gf571_kmul_sched.sv
// rtl/gf571_kmul_sched.sv - single-level Karatsuba schedule around one shared 286x286 GF(2) multiplier
module gf571_kmul_sched import gf571_pkg::*; #(
  parameter int MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  gf571_kmul_sched_if.slave      bus,
  output logic [W_HI-1:0]        mul_a,
  output logic [W_HI-1:0]        mul_b,
  output logic                   mul_issue,
  input  logic [CORE_PROD_W-1:0] mul_d,
  output logic                   busy
);

  state_t                 state, state_next;
  ks_step_t               k_cnt, mul_k;
  logic [GF_M-1:0]        a_reg, b_reg;
  logic [W_HI-1:0]        a_lo, a_hi, b_lo, b_hi;
  logic [W_HI-1:0]        op_a, op_b;
  logic [CORE_PROD_W-1:0] z0, z1, z2, z_mid;
  logic [PROD_W-1:0]      d_reg, d_comb;
  tag_t                   tag_in, tag_out;
  logic                   cap_z2;

  // Low halves are one bit narrower than the core, so they are zero-extended.
  assign a_lo = {{(W_HI-W_LO){1'b0}}, a_reg[W_LO-1:0]};
  assign a_hi = a_reg[GF_M-1:W_LO];
  assign b_lo = {{(W_HI-W_LO){1'b0}}, b_reg[W_LO-1:0]};
  assign b_hi = b_reg[GF_M-1:W_LO];

  // The tag leaves the registers together with the operands it describes.
  assign tag_in = {mul_issue, mul_k};
  assign cap_z2 = tag_out.valid && (tag_out.k == KS_Z2);

  gf571_kmul_tagpipe #(.DEPTH(MUL_LAT)) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Operand pair for the current Karatsuba step.
  always_comb begin
    op_a = a_hi;
    op_b = b_hi;
    case (k_cnt)
      KS_Z0: begin
        op_a = a_lo;
        op_b = b_lo;
      end
      KS_Z1: begin
        op_a = a_lo ^ a_hi;
        op_b = b_lo ^ b_hi;
      end
      default: begin
        op_a = a_hi;
        op_b = b_hi;
      end
    endcase
  end

  // Recombination: z2*x^570 + (z0+z1+z2)*x^285 + z0; the middle term cancels the cross products.
  always_comb begin
    z_mid  = z0 ^ z1 ^ z2;
    d_comb = (PROD_W'(z2) << (2*W_LO)) ^ (PROD_W'(z_mid) << W_LO) ^ PROD_W'(z0);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (bus.in_valid)      state_next = ST_ISSUE;
      ST_ISSUE:   if (k_cnt == KS_Z2)    state_next = ST_WAIT;
      ST_WAIT:    if (cap_z2)            state_next = ST_COMBINE;
      ST_COMBINE:                        state_next = ST_DONE;
      ST_DONE:    if (bus.out_ready)     state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // Operand capture, core issue, result capture and product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      k_cnt     <= KS_Z0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_issue <= 1'b0;
      mul_k     <= KS_Z0;
      z0        <= '0;
      z1        <= '0;
      z2        <= '0;
      d_reg     <= '0;
    end else begin
      if (state == ST_IDLE && bus.in_valid) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        k_cnt <= KS_Z0;
      end

      mul_issue <= (state == ST_ISSUE);
      if (state == ST_ISSUE) begin
        mul_a <= op_a;
        mul_b <= op_b;
        mul_k <= k_cnt;
        case (k_cnt)
          KS_Z0:   k_cnt <= KS_Z1;
          KS_Z1:   k_cnt <= KS_Z2;
          default: k_cnt <= k_cnt;
        endcase
      end

      if (tag_out.valid) begin
        case (tag_out.k)
          KS_Z0:   z0 <= mul_d;
          KS_Z1:   z1 <= mul_d;
          default: z2 <= mul_d;
        endcase
      end

      if (state == ST_COMBINE) d_reg <= d_comb;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) && !rst;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.d         = d_reg;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_gf571_kmul_sched.sv
// tb/tb_gf571_kmul_sched.sv - self-checking bench for gf571_kmul_sched across core latencies 0,1,2,5
module tb_gf571_kmul_sched;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  out_ready;
  logic [570:0]  a, b;
  logic [N-1:0]  in_ready, out_valid, iss_arr, busy;
  logic [1140:0] d_arr    [N];
  logic [285:0]  mula_arr [N];
  logic [1140:0] sb [N][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [570:0] clmul_core(input logic [285:0] x, input logic [285:0] y);
    logic [570:0] r;
    r = '0;
    for (int i = 0; i < 286; i++) if (y[i]) r ^= {285'b0, x} << i;
    return r;
  endfunction

  function automatic logic [1140:0] clmul_full(input logic [570:0] x, input logic [570:0] y);
    logic [1140:0] r;
    r = '0;
    for (int i = 0; i < 571; i++) if (y[i]) r ^= {570'b0, x} << i;
    return r;
  endfunction

  function automatic logic [570:0] rand571();
    logic [575:0] t;
    for (int w = 0; w < 18; w++) t[w*32 +: 32] = $urandom;
    return t[570:0];
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 0 : (gi == 1) ? 1 : (gi == 2) ? 2 : 5;
    gf571_kmul_sched_if bus();
    logic [285:0] mul_a, mul_b;
    logic         mul_issue, bsy;
    logic [570:0] mul_d;

    assign bus.in_valid  = in_valid[gi];
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.out_ready = out_ready[gi];
    assign in_ready[gi]  = bus.in_ready;
    assign out_valid[gi] = bus.out_valid;
    assign d_arr[gi]     = bus.d;
    assign mula_arr[gi]  = mul_a;
    assign iss_arr[gi]   = mul_issue;
    assign busy[gi]      = bsy;

    gf571_kmul_sched #(.MUL_LAT(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_issue (mul_issue),
      .mul_d     (mul_d),
      .busy      (bsy)
    );

    if (L == 0) begin : g_core_comb
      assign mul_d = clmul_core(mul_a, mul_b);
    end else begin : g_core_pipe
      logic [570:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= clmul_core(mul_a, mul_b);
        for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
      end
      assign mul_d = pipe[L-1];
    end
  end

  task automatic chk(input string tag, input logic [1140:0] obs, input logic [1140:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed_lo=%h expected_lo=%h differing_bits=%0d",
             tag, obs[127:0], exp[127:0], $countones(obs ^ exp));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_in_ready"},  in_ready[i],  1'b0);
      chk({tag, "_out_valid"}, out_valid[i], 1'b0);
      chk({tag, "_busy"},      busy[i],      1'b0);
      chk({tag, "_mul_issue"}, iss_arr[i],   1'b0);
      chk({tag, "_mul_a"},     mula_arr[i],  '0);
      chk({tag, "_d"},         d_arr[i],     '0);
    end
  endtask

  task automatic wait_idle(input logic [N-1:0] mask);
    int n;
    n = 0;
    while (((busy & mask) != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", ((busy & mask) == 0), 1'b1);
  endtask

  task automatic run_op(input logic [N-1:0] mask, input logic [570:0] av, input logic [570:0] bv);
    a = av;
    b = bv;
    in_valid = mask;
    @(posedge clk); #1;
    in_valid = '0;
    wait_idle(mask);
  endtask

  // Scoreboard: push golden product on acceptance, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        chk("in_ready_vs_busy", in_ready[i], !busy[i]);
        if (in_valid[i] && in_ready[i]) sb[i].push_back(clmul_full(a, b));
        if (out_valid[i] && out_ready[i]) begin
          chk("sb_nonempty", (sb[i].size() != 0), 1'b1);
          if (sb[i].size() != 0) chk("sb_d", d_arr[i], sb[i].pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1140:0] held, expv;
    logic [570:0]  r;

    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    a = '0;
    b = '0;
    @(posedge clk); #1;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) chk("idle_in_ready", in_ready[i], 1'b1);

    // Latency / issue timing on the MUL_LAT=2 instance.
    a = 571'd1;
    b = 571'd1;
    in_valid = 4'b0100;
    @(posedge clk); #1;
    in_valid = '0;
    chk("lat_busy", busy[2], 1'b1);
    chk("lat_issue0", iss_arr[2], 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      chk("lat_issue", iss_arr[2], (c >= 1 && c <= 3));
      chk("lat_out_valid", out_valid[2], (c == 7));
      if (c <= 3) chk("lat_mul_a", mula_arr[2], (c == 3) ? 1'b0 : 1'b1);
      if (c == 7) chk("lat_d", d_arr[2], 1'b1);
    end
    chk("lat_back_idle", busy[2], 1'b0);

    // Top bit reachable only through z2.
    r = '0; r[570] = 1'b1;
    run_op('1, r, r);
    expv = '0; expv[1140] = 1'b1;
    for (int i = 0; i < N; i++) chk("top_bit", d_arr[i], expv);

    // Middle-only product: cross terms must cancel.
    r = '0; r[285] = 1'b1;
    run_op('1, r, r);
    expv = '0; expv[570] = 1'b1;
    for (int i = 0; i < N; i++) chk("mid_bit", d_arr[i], expv);

    // Zero operand.
    run_op('1, '0, rand571());
    for (int i = 0; i < N; i++) chk("zero_a", d_arr[i], '0);

    // All-ones times one.
    r = '1;
    run_op('1, r, 571'd1);
    for (int i = 0; i < N; i++) chk("ones_x_one", d_arr[i], {570'b0, r});

    // Backpressure on the MUL_LAT=2 instance.
    out_ready[2] = 1'b0;
    a = rand571();
    b = rand571();
    in_valid = 4'b0100;
    @(posedge clk); #1;
    in_valid = '0;
    for (int n = 0; n < 30 && !out_valid[2]; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_reached", out_valid[2], 1'b1);
    held = d_arr[2];
    a = rand571();
    b = rand571();
    in_valid = 4'b0100;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid[2], 1'b1);
      chk("bp_d_stable", d_arr[2], held);
      chk("bp_in_ready", in_ready[2], 1'b0);
      chk("bp_busy", busy[2], 1'b1);
    end
    in_valid = '0;
    out_ready[2] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid[2], 1'b0);
    chk("bp_release_idle", busy[2], 1'b0);
    chk("bp_release_d", d_arr[2], held);

    // Reset with core results in flight.
    a = rand571();
    b = rand571();
    in_valid = '1;
    @(posedge clk); #1;
    in_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    for (int i = 0; i < N; i++) sb[i].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_op('1, 571'd3, 571'd3);
    for (int i = 0; i < N; i++) chk("post_rst_d", d_arr[i], 1141'd5);

    // Random sweep on all latencies in parallel.
    for (int n = 0; n < 1000; n++) run_op('1, rand571(), rand571());

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk("sb_drained", sb[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
